// File: rtl/sqrt_conv_param.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_conv_param
// Purpose  : Integer square root floor(sqrt(arg)) of an unsigned ARG_WIDTH-bit
//            argument. Bit-serial restoring algorithm, one result bit per
//            clock, ready/valid handshakes on both the argument and result
//            sides.
// Ports    : clk        - rising-edge clock
//            reset      - synchronous, active-high reset
//            arg_valid  - upstream offers an argument
//            arg_ready  - block is idle and accepts an argument
//            arg        - unsigned argument (ARG_WIDTH bits)
//            sqrt_valid - result is presented
//            sqrt_ready - downstream accepts the result
//            sqrt_res   - floor(sqrt(arg)) (RES_WIDTH bits)
//            busy       - conversion in progress or result pending
//            sqrt_rem   - arg - sqrt_res^2 (RES_WIDTH+1 bits); only present
//                         when SQRT_CONV_REM_EN is defined
// Config   : SQRT_CONV_REM_EN - adds the sqrt_rem port and its output register
// Revision : 1.0 - initial release
// ============================================================================
module sqrt_conv_param #(
    parameter  int ARG_WIDTH = 8,
    localparam int RES_WIDTH = ARG_WIDTH / 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arg_valid,
    output logic                 arg_ready,
    input  logic [ARG_WIDTH-1:0] arg,
    output logic                 sqrt_valid,
    input  logic                 sqrt_ready,
    output logic [RES_WIDTH-1:0] sqrt_res,
    output logic                 busy
`ifdef SQRT_CONV_REM_EN
   ,output logic [RES_WIDTH:0]   sqrt_rem
`endif
);

    // Reject odd or too-small argument widths at elaboration.
    generate
        if ((ARG_WIDTH < 2) || ((ARG_WIDTH % 2) != 0)) begin : g_arg_width_check
            $error("sqrt_conv_param: ARG_WIDTH must be even and at least 2");
        end
    endgenerate

    localparam int CNT_W = (RES_WIDTH > 1) ? $clog2(RES_WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [ARG_WIDTH-1:0] r_radicand;
    logic [RES_WIDTH-1:0] r_root;
    logic [RES_WIDTH+1:0] r_rem;
    logic [CNT_W-1:0]     r_count;
    logic [RES_WIDTH-1:0] r_res;
`ifdef SQRT_CONV_REM_EN
    logic [RES_WIDTH:0]   r_rem_out;
`endif

    // One restoring iteration. While the root still has fewer than RES_WIDTH
    // bits the running remainder is at most 2*root < 2^RES_WIDTH, so only its
    // low RES_WIDTH bits take part in the shift.
    logic [RES_WIDTH+1:0] w_shifted;
    logic [RES_WIDTH+1:0] w_subtrahend;
    logic [RES_WIDTH+2:0] w_trial;
    logic                 w_trial_neg;
    logic [RES_WIDTH+1:0] w_next_rem;
    logic [RES_WIDTH:0]   w_root_ext;
    logic [RES_WIDTH-1:0] w_next_root;
    logic                 w_unused;

    assign w_shifted    = {r_rem[RES_WIDTH-1:0], r_radicand[ARG_WIDTH-1 -: 2]};
    assign w_subtrahend = {r_root, 2'b01};
    // Extra top bit acts as the sign of the trial subtraction.
    assign w_trial      = {1'b0, w_shifted} - {1'b0, w_subtrahend};
    assign w_trial_neg  = w_trial[RES_WIDTH+2];
    assign w_next_rem   = w_trial_neg ? w_shifted : w_trial[RES_WIDTH+1:0];
    assign w_root_ext   = {r_root, ~w_trial_neg};
    assign w_next_root  = w_root_ext[RES_WIDTH-1:0];

    // Bits that are provably zero by the remainder bound above.
    assign w_unused = ^{r_rem[RES_WIDTH+1:RES_WIDTH], w_root_ext[RES_WIDTH],
                        w_next_rem[RES_WIDTH+1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_radicand <= '0;
            r_root     <= '0;
            r_rem      <= '0;
            r_count    <= '0;
            r_res      <= '0;
`ifdef SQRT_CONV_REM_EN
            r_rem_out  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arg_valid) begin
                        r_radicand <= arg;
                        r_root     <= '0;
                        r_rem      <= '0;
                        r_count    <= CNT_W'(RES_WIDTH - 1);
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_radicand <= r_radicand << 2;
                    r_root     <= w_next_root;
                    r_rem      <= w_next_rem;
                    r_count    <= r_count - CNT_W'(1);
                    if (r_count == '0) begin
                        // Last bit resolved: capture the result registers so
                        // they stay stable through DONE.
                        r_res     <= w_next_root;
`ifdef SQRT_CONV_REM_EN
                        r_rem_out <= w_next_rem[RES_WIDTH:0];
`endif
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (sqrt_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake flags depend on the state register only.
    assign arg_ready  = (r_state == S_IDLE);
    assign sqrt_valid = (r_state == S_DONE);
    assign busy       = (r_state == S_CALC) || (r_state == S_DONE);
    assign sqrt_res   = r_res;
`ifdef SQRT_CONV_REM_EN
    assign sqrt_rem   = r_rem_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sqrt_conv_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sqrt_conv_param
// Purpose  : Scoreboard bench for sqrt_conv_param at ARG_WIDTH=8 and 16.
//            Drivers push the expected result of every accepted argument into
//            a queue; monitors pop and compare on each result handshake.
//            Honours SQRT_CONV_REM_EN for the remainder port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sqrt_conv_param;

    localparam int R8  = 4;
    localparam int R16 = 8;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;

    logic        av8 = 1'b0, sr8 = 1'b0, ar8, sv8, busy8;
    logic [7:0]  a8  = '0;
    logic [3:0]  res8;
    logic        av16 = 1'b0, sr16 = 1'b0, ar16, sv16, busy16;
    logic [15:0] a16 = '0;
    logic [7:0]  res16;
`ifdef SQRT_CONV_REM_EN
    logic [4:0]  rem8;
    logic [8:0]  rem16;
`endif

    sqrt_conv_param #(.ARG_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset),
        .arg_valid(av8), .arg_ready(ar8), .arg(a8),
        .sqrt_valid(sv8), .sqrt_ready(sr8), .sqrt_res(res8),
        .busy(busy8)
`ifdef SQRT_CONV_REM_EN
       ,.sqrt_rem(rem8)
`endif
    );

    sqrt_conv_param #(.ARG_WIDTH(16)) dut16 (
        .clk(clk), .reset(reset),
        .arg_valid(av16), .arg_ready(ar16), .arg(a16),
        .sqrt_valid(sv16), .sqrt_ready(sr16), .sqrt_res(res16),
        .busy(busy16)
`ifdef SQRT_CONV_REM_EN
       ,.sqrt_rem(rem16)
`endif
    );

    typedef struct {
        int unsigned arg;
        int unsigned res;
        int unsigned rem;
        int          exp_cyc;
    } exp_t;

    exp_t sb8[$];
    exp_t sb16[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    bit rdy_rand8  = 1'b0;
    bit rdy_val8   = 1'b1;
    bit rdy_rand16 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: largest r with r*r <= a, found by plain search.
    function automatic void ref_sqrt(input int unsigned a, output int unsigned r,
                                     output int unsigned m);
        r = 0;
        while (longint'(r + 1) * longint'(r + 1) <= longint'(a)) r++;
        m = a - r * r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Result-ready drivers
    initial begin
        forever begin
            @(posedge clk);
            #1;
            sr8  = rdy_rand8  ? 1'($urandom_range(0, 1)) : rdy_val8;
            sr16 = rdy_rand16 ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor, 8-bit instance
    bit prev_sv8 = 1'b0, hs_pend8 = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (hs_pend8) chk("idle_after_hs8", {ar8, sv8}, 2'b10);
            hs_pend8 = 1'b0;
            if (sv8) begin
                if (sb8.size() == 0) begin
                    fail_now("unexpected_result8");
                end else begin
                    if (!prev_sv8) chk("latency8", cyc, sb8[0].exp_cyc);
                    chk("res8", res8, sb8[0].res);
`ifdef SQRT_CONV_REM_EN
                    chk("rem8", rem8, sb8[0].rem);
`endif
                    chk("flags_done8", {ar8, busy8}, 2'b01);
                    if (sr8) begin
                        void'(sb8.pop_front());
                        hs_pend8 = 1'b1;
                    end
                end
            end
        end else begin
            hs_pend8 = 1'b0;
        end
        prev_sv8 = sv8;
    end

    // Monitor, 16-bit instance
    bit prev_sv16 = 1'b0;
    always @(negedge clk) begin
        if (!reset && sv16) begin
            if (sb16.size() == 0) begin
                fail_now("unexpected_result16");
            end else begin
                if (!prev_sv16) chk("latency16", cyc, sb16[0].exp_cyc);
                chk("res16", res16, sb16[0].res);
`ifdef SQRT_CONV_REM_EN
                chk("rem16", rem16, sb16[0].rem);
`endif
                if (sr16) void'(sb16.pop_front());
            end
        end
        prev_sv16 = sv16;
    end

    // Present an argument, wait for acceptance, log the expected result.
    task automatic send8(input int unsigned a);
        int unsigned r, m;
        int t;
        ref_sqrt(a, r, m);
        a8  = a[7:0];
        av8 = 1'b1;
        t   = 0;
        @(negedge clk);
        while (!ar8 && t < 200) begin @(negedge clk); t++; end
        if (!ar8) begin
            fail_now("accept8");
            av8 = 1'b0;
        end else begin
            sb8.push_back('{a, r, m, cyc + 1 + R8});
            @(posedge clk);
            #1;
            av8 = 1'b0;
        end
    endtask

    task automatic send16(input int unsigned a);
        int unsigned r, m;
        int t;
        ref_sqrt(a, r, m);
        a16  = a[15:0];
        av16 = 1'b1;
        t    = 0;
        @(negedge clk);
        while (!ar16 && t < 200) begin @(negedge clk); t++; end
        if (!ar16) begin
            fail_now("accept16");
            av16 = 1'b0;
        end else begin
            sb16.push_back('{a, r, m, cyc + 1 + R16});
            @(posedge clk);
            #1;
            av16 = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((sb8.size() != 0 || sb16.size() != 0 || !ar8 || !ar16) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) fail_now(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0, t1, t2, t3, t;
        int unsigned r, m;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_flags8", {ar8, sv8, busy8}, 3'b100);
        chk("reset_res8", res8, 0);
        chk("reset_flags16", {ar16, sv16, busy16}, 3'b100);
`ifdef SQRT_CONV_REM_EN
        chk("reset_rem8", rem8, 0);
`endif
        @(posedge clk);
        #1;

        // Single conversion with the consumer always ready
        send8(144);
        drain("drain_144");

        // Back-to-back: accepts must be RES_WIDTH+2 cycles apart
        send8(9);  t0 = cyc;
        send8(10); t1 = cyc;
        send8(11); t2 = cyc;
        chk("b2b_gap_a", t1 - t0, R8 + 2);
        chk("b2b_gap_b", t2 - t1, R8 + 2);
        drain("drain_b2b");

        // Backpressure: result held, new arguments ignored
        rdy_val8 = 1'b0;
        @(posedge clk);
        #1;
        send8(200);
        ref_sqrt(200, r, m);
        t = 0;
        @(negedge clk);
        while (!sv8 && t < 50) begin @(negedge clk); t++; end
        if (!sv8) fail_now("bp_valid");
        a8  = 8'd77;
        av8 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", sv8, 1);
            chk("bp_hold_res", res8, r);
            chk("bp_arg_ready", ar8, 0);
        end
        @(posedge clk);
        #1;
        av8 = 1'b0;
        rdy_val8 = 1'b1;
        drain("drain_bp");
        chk("bp_ignored_arg", sb8.size(), 0);

        // Reset while converting: the result must never appear
        @(negedge clk);
        a8  = 8'd81;
        av8 = 1'b1;
        @(posedge clk);
        #1;
        av8 = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midcalc_reset_flags", {ar8, sv8, busy8}, 3'b100);
        chk("midcalc_reset_res", res8, 0);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1;

        // Exhaustive 8-bit sweep then random arguments, random consumer stalls
        rdy_rand8 = 1'b1;
        for (int a = 0; a < 256; a++) send8(a);
        for (int i = 0; i < 100; i++) send8($urandom_range(0, 255));
        drain("drain_sweep8");
        rdy_rand8 = 1'b0;

        // 16-bit instance: boundaries, then random arguments with stalls
        send16(65535);
        send16(40000);
        send16(0);
        send16(1);
        rdy_rand16 = 1'b1;
        for (int i = 0; i < 40; i++) send16($urandom_range(0, 65535));
        drain("drain16");

        t3 = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + t3);
        $finish;
    end

endmodule
`default_nettype wire
